// File: rtl/bcd_operand_loader.sv
// Two-operand BCD entry stage: debounced load key captures X, then Y + carry-in.
// Optional S_WAIT_Y abort timer enabled by defining BCD_LOADER_TIMEOUT_EN.
module bcd_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic       CLOCK_50,
  input  logic       RESETn,
  input  logic [3:0] SW_D,
  input  logic       SW_CIN,
  input  logic       KEY_LOADn,
  output logic [3:0] X,
  output logic [3:0] Y,
  output logic       CIN,
  output logic       VALID,
  output logic       ERR,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    S_IDLE_X = 2'b00,
    S_WAIT_Y = 2'b01,
    S_READY  = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic             key_s1, key_s2, key_db;
  logic [CNT_W-1:0] db_cnt;
  logic             db_hit, load_p;
  logic [3:0]       sw_d_q;
  logic             sw_cin_q;
  logic             digit_ok;
  logic             tmo_hit;
  logic [3:0]       x_q, x_d, y_q, y_d;
  logic             cin_q, cin_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  // Counter only runs while a level change is pending; any bounce back clears it.
  assign db_hit = (key_s2 != key_db) &&
                  (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign load_p = db_hit && !key_s2;

  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      key_db <= 1'b1;
      db_cnt <= '0;
    end else begin
      key_s1 <= KEY_LOADn;
      key_s2 <= key_s1;
      if (key_s2 == key_db) begin
        db_cnt <= '0;
      end else if (db_hit) begin
        key_db <= key_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      sw_d_q   <= '0;
      sw_cin_q <= 1'b0;
    end else begin
      sw_d_q   <= SW_D;
      sw_cin_q <= SW_CIN;
    end
  end

  assign digit_ok = ~sw_d_q[3] | (sw_d_q[2:1] == 2'b00);

`ifdef BCD_LOADER_TIMEOUT_EN
  logic [CNT_W-1:0] tmo_cnt;

  assign tmo_hit = (state_q == S_WAIT_Y) && !load_p &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      tmo_cnt <= '0;
    end else if (state_q != S_WAIT_Y || load_p) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_IDLE_X;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE_X: if (load_p && digit_ok) state_d = S_WAIT_Y;
      S_WAIT_Y: begin
        if (load_p && digit_ok) state_d = S_READY;
        else if (tmo_hit)       state_d = S_IDLE_X;
      end
      S_READY:  if (load_p) state_d = S_IDLE_X;
      default:  state_d = S_IDLE_X;
    endcase
  end

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    cin_d = cin_q;
    err_d = err_q;
    case (state_q)
      S_IDLE_X: begin
        if (load_p) begin
          if (digit_ok) begin
            x_d   = sw_d_q;
            err_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WAIT_Y: begin
        if (load_p) begin
          if (digit_ok) begin
            y_d   = sw_d_q;
            cin_d = sw_cin_q;
            err_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else if (tmo_hit) begin
          x_d   = 4'd0;
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
    valid_d = (state_d == S_READY);
  end

  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      x_q     <= '0;
      y_q     <= '0;
      cin_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      cin_q   <= cin_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign X     = x_q;
  assign Y     = y_q;
  assign CIN   = cin_q;
  assign VALID = valid_q;
  assign ERR   = err_q;
  assign STATE = state_q;

endmodule

// File: tb/tb_bcd_operand_loader.sv
// Directed bench for bcd_operand_loader: vector table of presses plus
// hand-written glitch, latency, async reset and timeout sequences.
module tb_bcd_operand_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw_d = '0;
  logic       sw_cin = 1'b0;
  logic       key_n = 1'b1;
  logic [3:0] x, y;
  logic       cin, valid, err;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_operand_loader #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(5),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .CLOCK_50(clk),
    .RESETn(rst_n),
    .SW_D(sw_d),
    .SW_CIN(sw_cin),
    .KEY_LOADn(key_n),
    .X(x),
    .Y(y),
    .CIN(cin),
    .VALID(valid),
    .ERR(err),
    .STATE(state)
  );

  typedef struct {
    logic [3:0] d;
    logic       c;
    logic [3:0] ex;
    logic [3:0] ey;
    logic       ecin;
    logic       evalid;
    logic       eerr;
    logic [1:0] est;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] d, input logic c);
    @(negedge clk);
    sw_d   = d;
    sw_cin = c;
    repeat (2) @(negedge clk);
    key_n = 1'b0;
    repeat (8) @(negedge clk);
    key_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int n;
    vecs[0] = '{4'd12, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 2'd0};
    vecs[1] = '{4'd3,  1'b0, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[2] = '{4'd11, 1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 2'd1};
    vecs[3] = '{4'd8,  1'b1, 4'd3, 4'd8, 1'b1, 1'b1, 1'b0, 2'd2};
    vecs[4] = '{4'd5,  1'b0, 4'd3, 4'd8, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[5] = '{4'd7,  1'b0, 4'd7, 4'd8, 1'b1, 1'b0, 1'b0, 2'd1};
    vecs[6] = '{4'd9,  1'b0, 4'd7, 4'd9, 1'b0, 1'b1, 1'b0, 2'd2};
    vecs[7] = '{4'd15, 1'b1, 4'd7, 4'd9, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[8] = '{4'd1,  1'b0, 4'd1, 4'd9, 1'b0, 1'b0, 1'b0, 2'd1};

    repeat (3) @(negedge clk);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_cin", int'(cin), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_state", int'(state), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // bouncy key: toggles every cycle, never stable long enough
    sw_d = 4'd6;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      key_n = ~key_n;
    end
    key_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_state", int'(state), 0);
    chk("glitch_x", int'(x), 0);

    for (int i = 0; i < 9; i++) begin
      press(vecs[i].d, vecs[i].c);
      chk($sformatf("v%0d_x", i), int'(x), int'(vecs[i].ex));
      chk($sformatf("v%0d_y", i), int'(y), int'(vecs[i].ey));
      chk($sformatf("v%0d_cin", i), int'(cin), int'(vecs[i].ecin));
      chk($sformatf("v%0d_valid", i), int'(valid), int'(vecs[i].evalid));
      chk($sformatf("v%0d_err", i), int'(err), int'(vecs[i].eerr));
      chk($sformatf("v%0d_state", i), int'(state), int'(vecs[i].est));
    end

    // press-to-VALID latency, bounded wait
    @(negedge clk);
    sw_d   = 4'd4;
    sw_cin = 1'b1;
    repeat (2) @(negedge clk);
    key_n = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (valid) break;
    end
    checks++;
    if (!valid || n < 5 || n > 7) begin
      errors++;
      $display("FAIL latency: got %0d cycles valid=%0b expected 5..7", n, valid);
    end
    chk("lat_y", int'(y), 4);
    @(negedge clk);
    key_n = 1'b1;
    repeat (8) @(negedge clk);

    press(4'd0, 1'b0);
    press(4'd5, 1'b0);
    chk("pre_rst_x", int'(x), 5);
    chk("pre_rst_state", int'(state), 1);

    // async reset mid-cycle, checked before any clock edge
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_x", int'(x), 0);
    chk("arst_state", int'(state), 0);
    chk("arst_valid", int'(valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    press(4'd6, 1'b0);
    chk("tmo_pre_x", int'(x), 6);
    repeat (25) @(negedge clk);
`ifdef BCD_LOADER_TIMEOUT_EN
    chk("tmo_state", int'(state), 0);
    chk("tmo_err", int'(err), 1);
    chk("tmo_x", int'(x), 0);
`else
    chk("tmo_state", int'(state), 1);
    chk("tmo_err", int'(err), 0);
    chk("tmo_x", int'(x), 6);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
